mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised multi-channel MMIO bridge between the core data port and N_CH peripheral channels. It replaces the single fixed combinational MMIO window with per-channel address windows and a request/acknowledge handshake, so peripherals may insert wait states. Decode misses are reported as bus errors, and so are (optionally) unresponsive peripherals. It sits between the core-side memory crossbar MMIO port and the peripheral blocks.

## Interface
- N_CH, 4: number of peripheral channels (1..8)
- ADDR_WIDTH, 30: word-address width
- DATA_WIDTH, 32: data width; must be a multiple of 8
- CH_BASE, 0: packed N_CH*ADDR_WIDTH inclusive window base per channel; channel k occupies slice k
- CH_LIMIT, 0: packed N_CH*ADDR_WIDTH inclusive window limit per channel
- TIMEOUT, 255: maximum wait cycles per access; 8-bit counter; valid range 1..255
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  core access request; held stable until o_ack
- i_addr  in  ADDR_WIDTH  word address
- i_data  in  DATA_WIDTH  write data
- i_mask  in  DATA_WIDTH/8  byte-enable mask
- i_wren  in  1  1 = write, 0 = read
- o_ack  out  1  one-cycle completion pulse
- o_data  out  DATA_WIDTH  read data; valid with o_ack
- o_err  out  1  bus error; valid with o_ack
- o_ch_req  out  N_CH  one-hot channel request
- o_ch_addr  out  ADDR_WIDTH  channel-relative address (i_addr - base)
- o_ch_data  out  DATA_WIDTH  write data, shared by all channels
- o_ch_mask  out  DATA_WIDTH/8  byte mask, shared by all channels
- o_ch_wren  out  1  write strobe, shared by all channels
- i_ch_ack  in  N_CH  per-channel acknowledge
- i_ch_data  in  N_CH*DATA_WIDTH  packed per-channel read data

## Operation
- FSM has three states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE:** i_req is sampled only in this state.
  - Decode is combinational, unsigned: hit on channel k when base_k <= i_addr <= limit_k. On overlapping windows the lowest index wins.
  - On a hit: latch channel index, offset, data, mask and wren; go to WAIT.
  - On a miss: set err=1, data=0; go to RESP.
- **WAIT:**
  - o_ch_req[idx]=1; address/data/mask/wren are driven from registers and held stable.
  - Acks on non-selected channels are ignored.
  - On i_ch_ack[idx]=1 at an edge: capture i_ch_data[idx] (reads only; writes capture 0), set err=0, drop o_ch_req, go to RESP.
- **RESP:** o_ack=1 for exactly one cycle with o_data/o_err, then go to IDLE.
  - If i_req is still high in the following IDLE cycle, it is treated as a new access.
- o_ch_addr offset width is ADDR_WIDTH; no wrap, since offset <= limit - base.
- **Reset mid-access:**
  - Everything returns to IDLE immediately.
  - o_ch_req drops asynchronously.
  - No o_ack is issued for the aborted access.

## Timing
- All outputs are registered.
- Reset values: o_ack=0, o_data=0, o_err=0, o_ch_req=0, o_ch_addr=0, o_ch_data=0, o_ch_mask=0, o_ch_wren=0.
- Hit with zero-wait slave (ack in the first WAIT cycle):
  - i_req sampled at edge 0
  - o_ch_req high in cycle 1
  - o_ack in cycle 2
- Each slave wait cycle adds 1 cycle of latency.
- Decode miss: o_ack with o_err=1 in cycle 1.
- Back-to-back accesses: minimum 3 cycles per channel access (IDLE, WAIT, RESP).
- Slave ack may be combinational from o_ch_req.
- An ack arriving while the bridge is not in WAIT for that channel is ignored.

## Configuration
- Macro: MMIO_TIMEOUT_EN.
- **Defined:**
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count equals TIMEOUT with no ack: err=1, data=0, o_ch_req drops, go to RESP.
  - Ack and timeout in the same cycle: the ack wins.
  - A late ack after a timeout is ignored.
- **Undefined:**
  - No counter is instantiated.
  - WAIT lasts until ack, with no bound.
  - o_err is raised only on a decode miss.

## Test plan
- **Zero-wait read:** N_CH=4, ch1 window 0x100..0x1FF, read 0x123, slave acks immediately with 0xDEADBEEF -> o_ch_addr=0x23, o_ch_req=4'b0010 in cycle 1, o_ack with o_data=0xDEADBEEF and o_err=0 in cycle 2.
- **Wait-state write:** write 0xCAFE0000 with mask 4'b1100 to ch0, ack after 5 cycles -> o_ch_data/o_ch_mask held stable for 5 cycles, o_ack at cycle 7, o_data=0.
- **Decode miss and overlap:** address outside all windows -> o_ack with o_err=1 in cycle 1 and no o_ch_req. Overlapping ch2/ch3 windows -> ch2 selected.
- **Timeout (MMIO_TIMEOUT_EN, TIMEOUT=10):** slave never acks -> o_ch_req high for 10 cycles, then o_ack with o_err=1. A later ack on that channel has no effect. Repeat with the ack landing on cycle 10 -> o_err=0.
- **Reset mid-WAIT:** rst pulsed during WAIT -> o_ch_req=0 immediately, no o_ack, and the next request completes normally.
- **Back-to-back accesses:** i_req held high across two accesses to different channels -> two o_ack pulses 3 cycles apart, with correct data for each.

Source files
------------

// File: rtl/mmio_bridge.sv
// mmio_bridge: multi-channel MMIO bridge between the core data port and N_CH
// peripheral channels. Each channel owns an inclusive word-address window
// [base, limit]; accesses use a request/acknowledge handshake so peripherals
// can insert wait states. Decode misses complete with a bus error.
//
// Optional feature macro: MMIO_TIMEOUT_EN
//   When defined, an 8-bit wait counter aborts an access with a bus error after
//   TIMEOUT wait cycles without acknowledge.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   i_req/i_addr/i_data/       core request (held until o_ack), word address,
//   i_mask/i_wren              write data, byte enables, write select
//   o_ack/o_data/o_err         one-cycle completion pulse, read data, bus error
//   o_ch_req                   one-hot channel request
//   o_ch_addr                  channel-relative word address (i_addr - base)
//   o_ch_data/o_ch_mask/       shared write data, byte mask, write strobe
//   o_ch_wren
//   i_ch_ack/i_ch_data         per-channel acknowledge, packed per-channel read data
module mmio_bridge #(
  parameter int unsigned              N_CH       = 4,
  parameter int unsigned              ADDR_WIDTH = 30,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [N_CH*ADDR_WIDTH-1:0] CH_BASE  = '0,
  parameter logic [N_CH*ADDR_WIDTH-1:0] CH_LIMIT = '0,
  parameter int unsigned              TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic [DATA_WIDTH/8-1:0]    i_mask,
  input  logic                       i_wren,
  output logic                       o_ack,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_err,
  output logic [N_CH-1:0]            o_ch_req,
  output logic [ADDR_WIDTH-1:0]      o_ch_addr,
  output logic [DATA_WIDTH-1:0]      o_ch_data,
  output logic [DATA_WIDTH/8-1:0]    o_ch_mask,
  output logic                       o_ch_wren,
  input  logic [N_CH-1:0]            i_ch_ack,
  input  logic [N_CH*DATA_WIDTH-1:0] i_ch_data
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
`ifdef MMIO_TIMEOUT_EN
  logic [7:0]        cnt_q;
`endif

  // Address decode. Scan from the highest index down so the lowest matching
  // channel is the last one written and therefore wins on overlap.
  logic                  hit;
  logic [IdxW-1:0]       hit_idx;
  logic [N_CH-1:0]       hit_oh;
  logic [ADDR_WIDTH-1:0] hit_off;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    hit_off = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_addr >= CH_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] &&
          i_addr <= CH_LIMIT[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit       = 1'b1;
        hit_idx   = IdxW'(k);
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
        hit_off   = i_addr - CH_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only the latched channel's ack and read data are observed.
  logic                  sel_ack;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_ack  = i_ch_ack[idx_q];
    sel_data = i_ch_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q     <= '0;
`endif
      o_ack     <= 1'b0;
      o_data    <= '0;
      o_err     <= 1'b0;
      o_ch_req  <= '0;
      o_ch_addr <= '0;
      o_ch_data <= '0;
      o_ch_mask <= '0;
      o_ch_wren <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          o_ack <= 1'b0;
          if (i_req) begin
            if (hit) begin
              idx_q     <= hit_idx;
              o_ch_req  <= hit_oh;
              o_ch_addr <= hit_off;
              o_ch_data <= i_data;
              o_ch_mask <= i_mask;
              o_ch_wren <= i_wren;
`ifdef MMIO_TIMEOUT_EN
              cnt_q     <= '0;
`endif
              state_q   <= StWait;
            end else begin
              o_ack   <= 1'b1;
              o_err   <= 1'b1;
              o_data  <= '0;
              state_q <= StResp;
            end
          end
        end
        StWait: begin
          if (sel_ack) begin
            // Writes return zero data.
            o_data   <= o_ch_wren ? '0 : sel_data;
            o_err    <= 1'b0;
            o_ack    <= 1'b1;
            o_ch_req <= '0;
            state_q  <= StResp;
`ifdef MMIO_TIMEOUT_EN
          end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
            // This cycle is the TIMEOUT-th wait cycle without ack.
            o_data   <= '0;
            o_err    <= 1'b1;
            o_ack    <= 1'b1;
            o_ch_req <= '0;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        StResp: begin
          o_ack   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed accesses with hand-computed
// expectations. Windows: ch0 0x000..0x0FF, ch1 0x100..0x1FF,
// ch2 0x200..0x2FF, ch3 0x280..0x3FF (ch2/ch3 overlap).
module tb_mmio_bridge;

  localparam int unsigned NCh = 4;
  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam logic [NCh*AW-1:0] Base  = {30'h280, 30'h200, 30'h100, 30'h000};
  localparam logic [NCh*AW-1:0] Limit = {30'h3FF, 30'h2FF, 30'h1FF, 30'h0FF};

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic [DW-1:0]     i_data;
  logic [DW/8-1:0]   i_mask;
  logic              i_wren;
  logic              o_ack;
  logic [DW-1:0]     o_data;
  logic              o_err;
  logic [NCh-1:0]    o_ch_req;
  logic [AW-1:0]     o_ch_addr;
  logic [DW-1:0]     o_ch_data;
  logic [DW/8-1:0]   o_ch_mask;
  logic              o_ch_wren;
  logic [NCh-1:0]    i_ch_ack;
  logic [NCh*DW-1:0] i_ch_data;

  int total = 0;
  int bad   = 0;

  mmio_bridge #(
    .N_CH       (NCh),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CH_BASE    (Base),
    .CH_LIMIT   (Limit),
    .TIMEOUT    (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_mask    (i_mask),
    .i_wren    (i_wren),
    .o_ack     (o_ack),
    .o_data    (o_data),
    .o_err     (o_err),
    .o_ch_req  (o_ch_req),
    .o_ch_addr (o_ch_addr),
    .o_ch_data (o_ch_data),
    .o_ch_mask (o_ch_mask),
    .o_ch_wren (o_ch_wren),
    .i_ch_ack  (i_ch_ack),
    .i_ch_data (i_ch_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] mask, input logic wren);
    i_req  = 1'b1;
    i_addr = addr;
    i_data = data;
    i_mask = mask;
    i_wren = wren;
  endtask

  initial begin
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    i_data    = '0;
    i_mask    = '0;
    i_wren    = 1'b0;
    i_ch_ack  = '0;
    i_ch_data = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    tick();
    tick();
    chk("rst_ack",   64'(o_ack),     64'd0);
    chk("rst_data",  64'(o_data),    64'd0);
    chk("rst_err",   64'(o_err),     64'd0);
    chk("rst_req",   64'(o_ch_req),  64'd0);
    chk("rst_addr",  64'(o_ch_addr), 64'd0);
    chk("rst_wdata", 64'(o_ch_data), 64'd0);
    chk("rst_mask",  64'(o_ch_mask), 64'd0);
    chk("rst_wren",  64'(o_ch_wren), 64'd0);
    rst = 1'b0;
    tick();

    // Zero-wait read of ch1.
    start(30'h123, 32'h0, 4'hF, 1'b0);
    tick();                                   // cycle 1
    chk("zw_req",  64'(o_ch_req),  64'h2);
    chk("zw_addr", 64'(o_ch_addr), 64'h23);
    chk("zw_ack1", 64'(o_ack),     64'd0);
    i_ch_ack = 4'b0010;
    tick();                                   // cycle 2
    chk("zw_ack",  64'(o_ack),    64'd1);
    chk("zw_data", 64'(o_data),   64'hDEADBEEF);
    chk("zw_err",  64'(o_err),    64'd0);
    chk("zw_reqd", 64'(o_ch_req), 64'd0);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();
    chk("zw_ack3", 64'(o_ack), 64'd0);

    // Decode miss.
    start(30'h500, 32'h0, 4'hF, 1'b0);
    tick();                                   // cycle 1
    chk("miss_ack",  64'(o_ack),    64'd1);
    chk("miss_err",  64'(o_err),    64'd1);
    chk("miss_data", 64'(o_data),   64'd0);
    chk("miss_req",  64'(o_ch_req), 64'd0);
    i_req = 1'b0;
    tick();
    chk("miss_ack2", 64'(o_ack), 64'd0);

    // Wait-state write to ch0, ack in the sixth WAIT cycle.
    start(30'h010, 32'hCAFE0000, 4'b1100, 1'b1);
    tick();                                   // cycle 1
    for (int c = 1; c <= 5; c++) begin
      chk("ws_req",   64'(o_ch_req),  64'h1);
      chk("ws_wdata", 64'(o_ch_data), 64'hCAFE0000);
      chk("ws_mask",  64'(o_ch_mask), 64'hC);
      chk("ws_wren",  64'(o_ch_wren), 64'd1);
      chk("ws_noack", 64'(o_ack),     64'd0);
      tick();
    end
    chk("ws_req6", 64'(o_ch_req), 64'h1);     // cycle 6
    i_ch_ack = 4'b0001;
    tick();                                   // cycle 7
    chk("ws_ack",  64'(o_ack),  64'd1);
    chk("ws_data", 64'(o_data), 64'd0);
    chk("ws_err",  64'(o_err),  64'd0);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();

    // Overlap: 0x290 falls in ch2 and ch3; ch2 wins. A ch3 ack is ignored.
    start(30'h290, 32'h0, 4'hF, 1'b0);
    tick();
    chk("ov_req",  64'(o_ch_req),  64'h4);
    chk("ov_addr", 64'(o_ch_addr), 64'h90);
    i_ch_ack = 4'b1100;
    tick();
    chk("ov_ack",  64'(o_ack),  64'd1);
    chk("ov_data", 64'(o_data), 64'h22222222);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();

`ifdef MMIO_TIMEOUT_EN
    // Slave never acks: ten request cycles, then error.
    start(30'h110, 32'h0, 4'hF, 1'b0);
    tick();
    for (int c = 1; c <= 10; c++) begin
      chk("to_req", 64'(o_ch_req), 64'h2);
      chk("to_noack", 64'(o_ack), 64'd0);
      tick();
    end
    chk("to_ack",  64'(o_ack),    64'd1);     // cycle 11
    chk("to_err",  64'(o_err),    64'd1);
    chk("to_data", 64'(o_data),   64'd0);
    chk("to_reqd", 64'(o_ch_req), 64'd0);
    i_req    = 1'b0;
    i_ch_ack = 4'b0010;                       // late ack
    tick();
    chk("to_late1", 64'(o_ack), 64'd0);
    tick();
    chk("to_late2", 64'(o_ack),    64'd0);
    chk("to_late3", 64'(o_ch_req), 64'd0);
    i_ch_ack = '0;
    tick();

    // Ack lands on the tenth wait cycle: ack wins.
    start(30'h110, 32'h0, 4'hF, 1'b0);
    tick();
    for (int c = 1; c <= 9; c++) tick();
    i_ch_ack = 4'b0010;                       // cycle 10
    tick();
    chk("tl_ack",  64'(o_ack),  64'd1);
    chk("tl_err",  64'(o_err),  64'd0);
    chk("tl_data", 64'(o_data), 64'hDEADBEEF);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();
`endif

    // Reset pulsed during WAIT.
    start(30'h180, 32'h0, 4'hF, 1'b0);
    tick();
    chk("rw_req", 64'(o_ch_req), 64'h2);
    #2;
    rst   = 1'b1;
    i_req = 1'b0;
    #1;
    chk("rw_async", 64'(o_ch_req), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rw_noack", 64'(o_ack), 64'd0);
    end
    start(30'h1A0, 32'h0, 4'hF, 1'b0);
    tick();
    chk("rw_req2", 64'(o_ch_req),  64'h2);
    chk("rw_addr", 64'(o_ch_addr), 64'hA0);
    i_ch_ack = 4'b0010;
    tick();
    chk("rw_ack",  64'(o_ack),  64'd1);
    chk("rw_data", 64'(o_data), 64'hDEADBEEF);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();

    // Back-to-back with i_req held: ch1 then ch3, acks three cycles apart.
    start(30'h120, 32'h0, 4'hF, 1'b0);
    tick();                                   // cycle 1
    chk("bb_req1", 64'(o_ch_req), 64'h2);
    i_ch_ack = 4'b0010;
    tick();                                   // cycle 2
    chk("bb_ack1",  64'(o_ack),  64'd1);
    chk("bb_data1", 64'(o_data), 64'hDEADBEEF);
    i_ch_ack = '0;
    i_addr   = 30'h350;
    tick();                                   // cycle 3
    chk("bb_gap", 64'(o_ack), 64'd0);
    tick();                                   // cycle 4
    chk("bb_req2",  64'(o_ch_req),  64'h8);
    chk("bb_addr2", 64'(o_ch_addr), 64'hD0);
    chk("bb_gap2",  64'(o_ack),     64'd0);
    i_ch_ack = 4'b1000;
    tick();                                   // cycle 5
    chk("bb_ack2",  64'(o_ack),  64'd1);
    chk("bb_data2", 64'(o_data), 64'h33333333);
    i_req    = 1'b0;
    i_ch_ack = '0;
    tick();
    chk("bb_end", 64'(o_ack), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
